// File: rtl/ct_mat_pkg.sv
// ============================================================================
// Module   : ct_mat_pkg
// Purpose  : Shared types and widths for the matrix pipe8 dispatch slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ct_mat_pkg;
    localparam int MAT_IID_W      = 7;
    localparam int MAT_META_W     = 31;
    localparam int MAT_ALU_META_W = 31;
    localparam int MAT_LSU_META_W = 16;
    localparam int MAT_CFG_META_W = 4;
    localparam int MAT_SRC_W      = 64;
    localparam int MAT_PREG_W     = 7;
    localparam int MAT_CNT_W      = 3;

    typedef enum logic [1:0] {
        MAT_CFG = 2'd0,
        MAT_ALU = 2'd1,
        MAT_LSU = 2'd2,
        MAT_ILL = 2'd3
    } mat_type_e;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_CFG_DRAIN = 2'd1,
        ST_CFG_WAIT  = 2'd2
    } disp_state_e;
endpackage

`default_nettype wire

// File: rtl/ct_mat_disp_outstd_tbl.sv
// ============================================================================
// Module   : ct_mat_disp_outstd_tbl
// Purpose  : In-flight matrix instruction table {vld, iid}; lowest-free
//            allocation, completion by iid match, live and post-completion count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_mat_disp_outstd_tbl
    import ct_mat_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_alloc,
    input  logic [MAT_IID_W-1:0] i_alloc_iid,
    input  logic                 i_cmplt,
    input  logic [MAT_IID_W-1:0] i_cmplt_iid,
    output logic [MAT_CNT_W-1:0] o_cnt,
    output logic [MAT_CNT_W-1:0] o_cnt_eff,
    output logic                 o_hit
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]     r_vld;
    logic [MAT_IID_W-1:0] r_iid [DEPTH];

    logic                 w_match;
    logic                 w_free;
    logic [IDX_W-1:0]     w_match_idx;
    logic [IDX_W-1:0]     w_free_idx;
    logic [MAT_CNT_W-1:0] w_cnt;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        w_cnt       = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_iid[i] == i_cmplt_iid)) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (!r_vld[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_vld[i]) begin
                w_cnt = w_cnt + MAT_CNT_W'(1);
            end
        end
    end

    assign o_hit     = i_cmplt & w_match;
    assign o_cnt     = w_cnt;
    assign o_cnt_eff = w_cnt - MAT_CNT_W'(o_hit);

    // Free slot is picked from the pre-completion view, so a slot released
    // this cycle only becomes allocatable on the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_iid[i] <= '0;
            end
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            if (o_hit) begin
                r_vld[w_match_idx] <= 1'b0;
            end
            if (i_alloc && w_free) begin
                r_vld[w_free_idx] <= 1'b1;
                r_iid[w_free_idx] <= i_alloc_iid;
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/ct_idu_mat_pipe8_disp.sv
// ============================================================================
// Module   : ct_idu_mat_pipe8_disp
// Purpose  : Pipe8 matrix dispatch: one-cycle issue to cfg/alu/lsu units with
//            cfg serialisation. Optional MAT_DISP_CMPLT_CHK_EN adds a sticky
//            unmatched-completion flag (mat_disp_cmplt_err).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_idu_mat_pipe8_disp
    import ct_mat_pkg::*;
#(
    parameter int OUTSTD_DEPTH = 4
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      rtu_yy_xx_flush,
    input  logic                      is_mat_vld,
    output logic                      mat_is_rdy,
    input  logic [1:0]                is_mat_type,
    input  logic [MAT_IID_W-1:0]      is_mat_iid,
    input  logic [MAT_META_W-1:0]     is_mat_meta,
    input  logic [MAT_SRC_W-1:0]      is_mat_src0,
    input  logic [MAT_SRC_W-1:0]      is_mat_src1,
    input  logic                      is_mat_src0_vld,
    input  logic                      is_mat_src1_vld,
    input  logic                      is_mat_dst_vld,
    input  logic [MAT_PREG_W-1:0]     is_mat_dst_preg,
    output logic                      idu_mat_rf_cfg_sel,
    output logic                      idu_mat_rf_alu_sel,
    output logic                      idu_mat_rf_lsu_sel,
    output logic                      idu_mat_rf_cfg_gateclk_sel,
    output logic                      idu_mat_rf_alu_gateclk_sel,
    output logic                      idu_mat_rf_lsu_gateclk_sel,
    output logic [MAT_IID_W-1:0]      idu_mat_rf_pipe8_iid,
    output logic [MAT_ALU_META_W-1:0] idu_mat_rf_pipe8_alu_meta,
    output logic [MAT_LSU_META_W-1:0] idu_mat_rf_pipe8_lsu_meta,
    output logic [MAT_CFG_META_W-1:0] idu_mat_rf_pipe8_cfg_meta,
    output logic [MAT_SRC_W-1:0]      idu_mat_rf_pipe8_alu_src0,
    output logic [MAT_SRC_W-1:0]      idu_mat_rf_pipe8_lsu_src0,
    output logic [MAT_SRC_W-1:0]      idu_mat_rf_pipe8_lsu_src1,
    output logic [MAT_SRC_W-1:0]      idu_mat_rf_pipe8_cfg_src0,
    output logic                      idu_mat_rf_pipe8_alu_src0_vld,
    output logic                      idu_mat_rf_pipe8_lsu_src1_vld,
    output logic                      idu_mat_rf_pipe8_cfg_dst_vld,
    output logic [MAT_PREG_W-1:0]     idu_mat_rf_pipe8_cfg_dst_preg,
    input  logic                      mat_rtu_pipe8_cmplt,
    input  logic [MAT_IID_W-1:0]      mat_rtu_pipe8_iid,
    output logic [MAT_CNT_W-1:0]      mat_disp_outstd_cnt,
    output logic                      mat_disp_idle,
`ifdef MAT_DISP_CMPLT_CHK_EN
    output logic                      mat_disp_cmplt_err,
`endif
    output logic                      mat_disp_illegal
);
    localparam logic [MAT_CNT_W-1:0] c_depth = MAT_CNT_W'(OUTSTD_DEPTH);

    disp_state_e          r_state;
    disp_state_e          w_nxt;
    logic [2:0]           r_sel;      // {cfg, alu, lsu}
    logic [2:0]           w_sel;
    logic                 r_ill;
    logic                 w_ill;
    logic                 w_rdy;
    logic                 w_acc;
    logic                 w_alloc;
    logic [MAT_IID_W-1:0] w_alloc_iid;
    logic [MAT_CNT_W-1:0] w_cnt;
    logic [MAT_CNT_W-1:0] w_cnt_eff;
    logic                 w_hit;

    logic [MAT_IID_W-1:0]  r_iid;
    logic [MAT_META_W-1:0] r_meta;
    logic [MAT_SRC_W-1:0]  r_src0;
    logic [MAT_SRC_W-1:0]  r_src1;
    logic                  r_src0_vld;
    logic                  r_src1_vld;
    logic                  r_dst_vld;
    logic [MAT_PREG_W-1:0] r_dst_preg;

    ct_mat_disp_outstd_tbl #(
        .DEPTH (OUTSTD_DEPTH)
    ) u_tbl (
        .clk         (forever_cpuclk),
        .rst         (cpurst),
        .i_flush     (rtu_yy_xx_flush),
        .i_alloc     (w_alloc),
        .i_alloc_iid (w_alloc_iid),
        .i_cmplt     (mat_rtu_pipe8_cmplt),
        .i_cmplt_iid (mat_rtu_pipe8_iid),
        .o_cnt       (w_cnt),
        .o_cnt_eff   (w_cnt_eff),
        .o_hit       (w_hit)
    );

    assign mat_is_rdy = w_rdy & ~cpurst;
    assign w_acc      = is_mat_vld & mat_is_rdy & ~rtu_yy_xx_flush;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt       = r_state;
        w_rdy       = 1'b0;
        w_sel       = 3'b000;
        w_ill       = 1'b0;
        w_alloc     = 1'b0;
        w_alloc_iid = is_mat_iid;
        case (r_state)
            ST_RUN: begin
                w_rdy = (w_cnt < c_depth);
                if (w_acc) begin
                    case (mat_type_e'(is_mat_type))
                        MAT_ALU: begin
                            w_sel   = 3'b010;
                            w_alloc = 1'b1;
                        end
                        MAT_LSU: begin
                            w_sel   = 3'b001;
                            w_alloc = 1'b1;
                        end
                        MAT_CFG: begin
                            if (w_cnt_eff == '0) begin
                                w_sel   = 3'b100;
                                w_alloc = 1'b1;
                                w_nxt   = ST_CFG_WAIT;
                            end else begin
                                w_nxt   = ST_CFG_DRAIN;
                            end
                        end
                        default: w_ill = 1'b1;
                    endcase
                end
            end
            // The held cfg sits in the payload registers while draining.
            ST_CFG_DRAIN: begin
                if (w_cnt_eff == '0) begin
                    w_sel       = 3'b100;
                    w_alloc     = 1'b1;
                    w_alloc_iid = r_iid;
                    w_nxt       = ST_CFG_WAIT;
                end
            end
            ST_CFG_WAIT: begin
                if (mat_rtu_pipe8_cmplt && (mat_rtu_pipe8_iid == r_iid)) begin
                    w_nxt = ST_RUN;
                end
            end
            default: w_nxt = ST_RUN;
        endcase
        if (rtu_yy_xx_flush) begin
            w_nxt   = ST_RUN;
            w_sel   = 3'b000;
            w_ill   = 1'b0;
            w_alloc = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_sel <= 3'b000;
            r_ill <= 1'b0;
        end else begin
            r_sel <= w_sel;
            r_ill <= w_ill;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_iid      <= '0;
            r_meta     <= '0;
            r_src0     <= '0;
            r_src1     <= '0;
            r_src0_vld <= 1'b0;
            r_src1_vld <= 1'b0;
            r_dst_vld  <= 1'b0;
            r_dst_preg <= '0;
        end else if (w_acc) begin
            r_iid      <= is_mat_iid;
            r_meta     <= is_mat_meta;
            r_src0     <= is_mat_src0;
            r_src1     <= is_mat_src1;
            r_src0_vld <= is_mat_src0_vld;
            r_src1_vld <= is_mat_src1_vld;
            r_dst_vld  <= is_mat_dst_vld;
            r_dst_preg <= is_mat_dst_preg;
        end
    end

`ifdef MAT_DISP_CMPLT_CHK_EN
    logic r_cmplt_err;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            r_cmplt_err <= 1'b0;
        end else if (mat_rtu_pipe8_cmplt && !w_hit) begin
            r_cmplt_err <= 1'b1;
        end
    end

    assign mat_disp_cmplt_err = r_cmplt_err;
`endif

    assign idu_mat_rf_cfg_sel            = r_sel[2];
    assign idu_mat_rf_alu_sel            = r_sel[1];
    assign idu_mat_rf_lsu_sel            = r_sel[0];
    assign idu_mat_rf_cfg_gateclk_sel    = r_sel[2];
    assign idu_mat_rf_alu_gateclk_sel    = r_sel[1];
    assign idu_mat_rf_lsu_gateclk_sel    = r_sel[0];
    assign idu_mat_rf_pipe8_iid          = r_iid;
    assign idu_mat_rf_pipe8_alu_meta     = r_meta[MAT_ALU_META_W-1:0];
    assign idu_mat_rf_pipe8_lsu_meta     = r_meta[MAT_LSU_META_W-1:0];
    assign idu_mat_rf_pipe8_cfg_meta     = r_meta[MAT_CFG_META_W-1:0];
    assign idu_mat_rf_pipe8_alu_src0     = r_src0;
    assign idu_mat_rf_pipe8_lsu_src0     = r_src0;
    assign idu_mat_rf_pipe8_lsu_src1     = r_src1;
    assign idu_mat_rf_pipe8_cfg_src0     = r_src0;
    assign idu_mat_rf_pipe8_alu_src0_vld = r_src0_vld;
    assign idu_mat_rf_pipe8_lsu_src1_vld = r_src1_vld;
    assign idu_mat_rf_pipe8_cfg_dst_vld  = r_dst_vld;
    assign idu_mat_rf_pipe8_cfg_dst_preg = r_dst_preg;
    assign mat_disp_outstd_cnt           = w_cnt;
    assign mat_disp_idle                 = (w_cnt == '0) && (r_state == ST_RUN);
    assign mat_disp_illegal              = r_ill;
endmodule

`default_nettype wire
